// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache
// between the MA stage and a line-wide main memory.
// Optional hit/miss counters are built when DCACHE_PERF_COUNTERS_EN is defined;
// otherwise HIT_COUNT/MISS_COUNT are tied to zero.
module dcache_controller #(
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned LINE_BITS  = 128
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [31:0]   ADDR,
    input  logic [31:0]   WRITEDATA,
    input  logic [3:0]    READ,
    input  logic [2:0]    WRITE,
    output logic [31:0]   READDATA,
    output logic          BUSYWAIT,
    output logic          MEM_READ,
    output logic          MEM_WRITE,
    output logic [27:0]   MEM_ADDRESS,
    output logic [127:0]  MEM_WRITEDATA,
    input  logic [127:0]  MEM_READDATA,
    input  logic          MEM_BUSYWAIT,
    output logic [31:0]   HIT_COUNT,
    output logic [31:0]   MISS_COUNT
);

    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_FETCH,
        S_UPDATE
    } state_t;

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [LINES-1:0]       dirty_q, dirty_d;
    logic [TAG_BITS-1:0]    tag_q  [LINES];
    logic [LINE_BITS-1:0]   data_q [LINES];
    logic [LINE_BITS-1:0]   fill_q, fill_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic [27:0]            mem_addr_q, mem_addr_d;
    logic [127:0]           mem_wdata_q, mem_wdata_d;

    logic [TAG_BITS-1:0]    addr_tag;
    logic [INDEX_BITS-1:0]  addr_idx;
    logic [1:0]             word_sel;
    logic [1:0]             byte_sel;
    logic                   access;
    logic                   hit;
    logic                   store_hit;
    logic [LINE_BITS-1:0]   cur_line;
    logic [31:0]            cur_word;
    logic [7:0]             load_byte;
    logic [15:0]            load_half;
    logic [31:0]            load_ext;
    logic [31:0]            store_bytes;
    logic [3:0]             store_mask;
    logic [31:0]            merged_word;
    logic [LINE_BITS-1:0]   merged_line;

    assign addr_tag  = ADDR[31:4+INDEX_BITS];
    assign addr_idx  = ADDR[3+INDEX_BITS:4];
    assign word_sel  = ADDR[3:2];
    assign byte_sel  = ADDR[1:0];
    assign access    = READ[3] | WRITE[2];
    assign hit       = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign cur_line  = data_q[addr_idx];
    assign cur_word  = cur_line[{word_sel, 5'b00000} +: 32];
    assign store_hit = (state_q == S_IDLE) && WRITE[2] && hit;

    assign BUSYWAIT      = access && !((state_q == S_IDLE) && hit);
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;
    assign READDATA      = READ[3] ? load_ext : '0;

    // Select and extend the loaded byte/halfword/word from the indexed line.
    always_comb begin
        load_byte = cur_word[{byte_sel, 3'b000} +: 8];
        load_half = cur_word[{byte_sel[1], 4'b0000} +: 16];
        case (READ[2:0])
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b010:  load_ext = cur_word;
            3'b100:  load_ext = {24'd0, load_byte};
            3'b101:  load_ext = {16'd0, load_half};
            default: load_ext = '0;
        endcase
    end

    // Merge store data into the addressed word according to the store size.
    always_comb begin
        store_bytes = WRITEDATA;
        case (WRITE[1:0])
            2'b00: begin
                store_bytes = {4{WRITEDATA[7:0]}};
                store_mask  = 4'b0001 << byte_sel;
            end
            2'b01: begin
                store_bytes = {2{WRITEDATA[15:0]}};
                store_mask  = byte_sel[1] ? 4'b1100 : 4'b0011;
            end
            2'b10:   store_mask = 4'b1111;
            default: store_mask = 4'b0000;
        endcase
        merged_word = cur_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (store_mask[b]) begin
                merged_word[b*8 +: 8] = store_bytes[b*8 +: 8];
            end
        end
        merged_line = cur_line;
        merged_line[{word_sel, 5'b00000} +: 32] = merged_word;
    end

    // Next-state, memory request and line status logic.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        fill_d      = fill_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (store_hit) begin
                    dirty_d[addr_idx] = 1'b1;
                end
                if (access && !hit) begin
                    if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
                        state_d     = S_WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[addr_idx], addr_idx};
                        mem_wdata_d = data_q[addr_idx];
                    end else begin
                        state_d    = S_FETCH;
                        mem_read_d = 1'b1;
                        mem_addr_d = ADDR[31:4];
                    end
                end
            end
            S_WRITEBACK: begin
                if (!MEM_BUSYWAIT) begin
                    state_d     = S_FETCH;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = ADDR[31:4];
                    mem_wdata_d = '0;
                end
            end
            S_FETCH: begin
                if (!MEM_BUSYWAIT) begin
                    state_d    = S_UPDATE;
                    fill_d     = MEM_READDATA;
                    mem_read_d = 1'b0;
                    mem_addr_d = '0;
                end
            end
            S_UPDATE: begin
                state_d           = S_IDLE;
                valid_d[addr_idx] = 1'b1;
                dirty_d[addr_idx] = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, registered memory interface and line status bits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            fill_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            fill_q      <= fill_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Tag and data arrays: written by store hits and by line refills.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (store_hit) begin
                data_q[addr_idx] <= merged_line;
            end else if (state_q == S_UPDATE) begin
                data_q[addr_idx] <= fill_q;
                tag_q[addr_idx]  <= addr_tag;
            end
        end
    end

`ifdef DCACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        miss_pending_q, miss_pending_d;

    // The retry that completes after a refill is not a hit; miss_pending marks it.
    always_comb begin
        hit_count_d    = hit_count_q;
        miss_count_d   = miss_count_q;
        miss_pending_d = miss_pending_q;
        if ((state_q == S_IDLE) && access) begin
            if (hit) begin
                if (!miss_pending_q) begin
                    hit_count_d = hit_count_q + 32'd1;
                end
                miss_pending_d = 1'b0;
            end else begin
                miss_count_d   = miss_count_q + 32'd1;
                miss_pending_d = 1'b1;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q    <= '0;
            miss_count_q   <= '0;
            miss_pending_q <= 1'b0;
        end else begin
            hit_count_q    <= hit_count_d;
            miss_count_q   <= miss_count_d;
            miss_pending_q <= miss_pending_d;
        end
    end

    assign HIT_COUNT  = hit_count_q;
    assign MISS_COUNT = miss_count_q;
`else
    assign HIT_COUNT  = '0;
    assign MISS_COUNT = '0;
`endif

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline's memory-access stage and a block-wide main memory.
- Consumes the stage's address, write data, read code and write code. Returns extended load data and a busywait that stalls the pipeline.
- Sits directly downstream of the cpu core's MA stage. Owns all main-memory traffic for data.

Parameters:
INDEX_BITS, 3, log2 of the number of cache lines (8 lines); tag width = 28 - INDEX_BITS
LINE_BITS, 128, line size in bits (4 words, 16 bytes); fixed, with the offset at ADDR[3:0]

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous active-high reset
ADDR  in  32  byte address from MA stage
WRITEDATA  in  32  store data from MA stage
READ  in  4  load code; [3]=enable, [2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
WRITE  in  3  store code; [2]=enable, [1:0]=size (00 SB, 01 SH, 10 SW)
READDATA  out  32  extended load result
BUSYWAIT  out  1  stall request to core
MEM_READ  out  1  main-memory block read request
MEM_WRITE  out  1  main-memory block write request
MEM_ADDRESS  out  28  block address (byte address [31:4])
MEM_WRITEDATA  out  128  victim line
MEM_READDATA  in  128  fill line
MEM_BUSYWAIT  in  1  main memory busy; a request completes on the first cycle it is low while the request is high
HIT_COUNT  out  32  see Optional Feature
MISS_COUNT  out  32  see Optional Feature

Behaviour:
- Address split: tag=ADDR[31:4+INDEX_BITS], index=ADDR[3+INDEX_BITS:4], word=ADDR[3:2], byte=ADDR[1:0].
- Halfword accesses ignore ADDR[0]. Word accesses ignore ADDR[1:0].
- Access is active when READ[3] or WRITE[2]. If both are set, the access is treated as a store.
- Per line: valid, dirty, tag, 128-bit data.
- Hit = valid[index] and tag match. Evaluated combinationally in IDLE.
- BUSYWAIT = access active and not (IDLE and hit). It rises in the same cycle as a missing request.
- Read hit: READDATA is combinational from the line. BUSYWAIT stays 0, so there is zero added latency.
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged. The funct3 codes 011/110/111 return 0.
- Write hit: the addressed bytes are written at the rising edge and dirty is set. Byte lanes: SB→1 byte at byte, SH→2 bytes at {byte[1],0}, SW→4 bytes.
- FSM states:
  - IDLE: on a miss, go to WRITEBACK if the victim is valid and dirty, else go to FETCH.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={victim tag,index}, MEM_WRITEDATA=victim line. On MEM_BUSYWAIT=0, go to FETCH.
  - FETCH: MEM_READ=1, MEM_ADDRESS=ADDR[31:4]. On MEM_BUSYWAIT=0, capture MEM_READDATA and go to UPDATE.
  - UPDATE: write the captured line with valid=1, dirty=0, tag=new tag. Return to IDLE. The access then hits on the next cycle and releases BUSYWAIT.
- Miss cost (memory answering after N busy cycles): clean miss = N+3 stall cycles, dirty miss = 2N+4.
- MEM_READ and MEM_WRITE are never high together, and are 0 in IDLE and UPDATE.
- The core holds ADDR, READ and WRITE stable while BUSYWAIT=1. The controller does not latch them.
- Reset:
  - All valid and dirty bits clear; FSM goes to IDLE.
  - Reset outputs: BUSYWAIT=0 if no access, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0 when no read.
  - Reset mid-WRITEBACK or mid-FETCH abandons the transfer; requests drop the cycle after the reset edge.
  - Tag and data arrays need not be cleared.
- Index wrap-around: addresses whose tags differ but whose indices match evict each other. There is no associativity.

Optional Feature:
- Macro DCACHE_PERF_COUNTERS_EN.
- Defined:
  - HIT_COUNT increments once per access completing in IDLE without entering the FSM.
  - MISS_COUNT increments once per IDLE→WRITEBACK/FETCH transition.
  - Both counters clear on RST and wrap at 2^32.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Cold LW from 0x00000040 with memory returning line {0xDDDDDDDD,0xCCCCCCCC,0xBBBBBBBB,0xAAAAAAAA} after N=5 busy cycles:
  - BUSYWAIT high for 8 cycles; MEM_READ high with MEM_ADDRESS=0x0000004.
  - READDATA=0xAAAAAAAA; a following LW to 0x44 hits with READDATA=0xBBBBBBBB and BUSYWAIT=0.
- Loads from line word 0x000080F0 at 0x40:
  - LB at 0x40 → 0xFFFFFFF0.
  - LBU at 0x40 → 0x000000F0.
  - LH at 0x40 → 0xFFFF80F0.
  - LHU at 0x42 → 0x00000000.
- Store hits at 0x40: SB 0x12 at 0x41, then SH 0x3456 at 0x42. A following LW at 0x40 returns 0x345612F0 with zero stall and dirty set.
- Dirty eviction:
  - Setup: the dirtied line from the previous scenario, then LW at 0x00000440 (same index, new tag).
  - MEM_WRITE first: MEM_ADDRESS=0x0000004, MEM_WRITEDATA[31:0]=0x345612F0.
  - Then MEM_READ: MEM_ADDRESS=0x0000044.
  - MEM_READ and MEM_WRITE are never both high.
- Assert RST during FETCH:
  - The next cycle shows MEM_READ=0 and the FSM in IDLE.
  - A re-issued LW at 0x40 misses again (valid cleared).
- With DCACHE_PERF_COUNTERS_EN, the sequence miss, hit, hit, miss ends with HIT_COUNT=2 and MISS_COUNT=2. Without the macro, both read 0.
